ysyx_pcctrl: RTL

YSYX_PCCTRL -- requirements
Module: ysyx_pcctrl

---
 rtl/ysyx_pcctrl_pkg.sv | 31 +++
 rtl/ysyx_pcctrl_cmp.sv | 34 +++
 rtl/ysyx_pcctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ysyx_pcctrl_pkg.sv
// Shared definitions for the next-PC controller: control-type encodings,
// FSM state enum and the sequential-PC helper.
package ysyx_pcctrl_pkg;

    localparam int unsigned XLEN = 32;

    // Control type of the resolved instruction, as presented on in_type.
    typedef enum logic [2:0] {
        CT_SEQ  = 3'b000,
        CT_JMP  = 3'b001,
        CT_BEQ  = 3'b010,
        CT_BNE  = 3'b011,
        CT_BLT  = 3'b100,
        CT_BGE  = 3'b101,
        CT_BLTU = 3'b110,
        CT_BGEU = 3'b111
    } ctl_type_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_IDLE = 2'd1,
        ST_EVAL = 2'd2,
        ST_SEND = 2'd3
    } state_e;

    // Fall-through address; wraps naturally at 2^32.
    function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/ysyx_pcctrl_cmp.sv
// Branch resolution: decides whether a control transfer is taken from
// its two operands and its control type. Purely combinational.
module ysyx_pcctrl_cmp
    import ysyx_pcctrl_pkg::*;
(
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  ctl_type_e       br_type,
    output logic            taken
);

    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;

    assign rs1_s = rs1;
    assign rs2_s = rs2;

    // Select the compare that matches the control type.
    always_comb begin
        taken = 1'b0;
        case (br_type)
            CT_SEQ:  taken = 1'b0;
            CT_JMP:  taken = 1'b1;
            CT_BEQ:  taken = (rs1 == rs2);
            CT_BNE:  taken = (rs1 != rs2);
            CT_BLT:  taken = (rs1_s <  rs2_s);
            CT_BGE:  taken = (rs1_s >= rs2_s);
            CT_BLTU: taken = (rs1 <  rs2);
            CT_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ysyx_pcctrl.sv
// Next-PC controller. Offers RESET_PC once after reset, then accepts one
// resolved control-transfer request at a time, evaluates it for a cycle
// and offers the resulting fetch address to the fetch unit.
// Optional feature: define YSYX_PCCTRL_STAT_EN to add the stat_total /
// stat_taken branch statistics outputs.
module ysyx_pcctrl
    import ysyx_pcctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [2:0]  in_type,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic        out_redirect,
    output logic        out_misalign
`ifdef YSYX_PCCTRL_STAT_EN
    ,
    output logic [31:0] stat_total,
    output logic [31:0] stat_taken
`endif
);

    state_e      state_q;
    state_e      state_d;

    logic [31:0] pc_q;
    ctl_type_e   type_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] target_q;

    logic        taken;
    logic [31:0] out_pc_q;
    logic        redirect_q;
    logic        misalign_q;

    ysyx_pcctrl_cmp u_cmp (
        .rs1     (rs1_q),
        .rs2     (rs2_q),
        .br_type (type_q),
        .taken   (taken)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_BOOT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Capture the request on the accepting handshake; in_valid is ignored elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            type_q   <= CT_SEQ;
            rs1_q    <= '0;
            rs2_q    <= '0;
            target_q <= '0;
        end else if (state_q == ST_IDLE && in_valid) begin
            pc_q     <= in_pc;
            type_q   <= ctl_type_e'(in_type);
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            target_q <= in_target;
        end
    end

    // Register the resolved offer in EVAL; it then holds through SEND and IDLE.
    // The reset value is the boot offer, which counts as a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pc_q   <= RESET_PC;
            redirect_q <= 1'b1;
            misalign_q <= 1'b0;
        end else if (state_q == ST_EVAL) begin
            out_pc_q   <= taken ? target_q : seq_pc(pc_q);
            redirect_q <= taken;
            misalign_q <= taken & (target_q[1:0] != 2'b00);
        end
    end

    assign out_pc       = out_pc_q;
    assign out_redirect = redirect_q;
    assign out_misalign = misalign_q;

`ifdef YSYX_PCCTRL_STAT_EN
    logic [31:0] total_q;
    logic [31:0] taken_cnt_q;

    // Count delivered control transfers (sequential requests excluded).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q     <= '0;
            taken_cnt_q <= '0;
        end else if (state_q == ST_SEND && out_ready && type_q != CT_SEQ) begin
            total_q <= total_q + 32'd1;
            if (redirect_q) taken_cnt_q <= taken_cnt_q + 32'd1;
        end
    end

    assign stat_total = total_q;
    assign stat_taken = taken_cnt_q;
`endif

endmodule
